// File: rtl/timer_countdown.sv
// ============================================================================
// Module   : timer_countdown
// Brief    : Keypad-loaded MM:SS BCD countdown timer with expiry pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_countdown #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       enablen,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       running,
  output logic       done
);

  typedef enum logic [1:0] {
    SET  = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_nine = 4'd9;
  localparam logic [3:0] c_five = 4'd5;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_load_sync;
  logic [SYNC_STAGES-1:0] r_tick_sync;
  logic                   r_load_prev;
  logic                   r_tick_prev;
  logic                   w_key_evt;
  logic                   w_tick_evt;

  logic [3:0] r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
  logic [3:0] w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
  logic [3:0] w_mt_dec, w_mo_dec, w_st_dec, w_so_dec;
  logic       w_dec_zero;
  logic       w_done_nxt;
  logic       r_running;
  logic       r_done;

  // Chains reset to the idle level of each input so release creates no edge.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_load_sync <= '1;
      r_tick_sync <= '0;
      r_load_prev <= 1'b1;
      r_tick_prev <= 1'b0;
    end else begin
      r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], loadn};
      r_tick_sync <= {r_tick_sync[SYNC_STAGES-2:0], pgt_1Hz};
      r_load_prev <= r_load_sync[SYNC_STAGES-1];
      r_tick_prev <= r_tick_sync[SYNC_STAGES-1];
    end
  end

  assign w_key_evt  = r_load_prev & ~r_load_sync[SYNC_STAGES-1];
  assign w_tick_evt = ~r_tick_prev & r_tick_sync[SYNC_STAGES-1];

  assign zero = (r_min_tens == 4'd0) && (r_min_ones == 4'd0) &&
                (r_sec_tens == 4'd0) && (r_sec_ones == 4'd0);

  // One-second BCD decrement; only used while the value is non-zero.
  always_comb begin
    w_mt_dec = r_min_tens;
    w_mo_dec = r_min_ones;
    w_st_dec = r_sec_tens;
    w_so_dec = r_sec_ones;
    if (r_sec_ones != 4'd0) begin
      w_so_dec = r_sec_ones - 4'd1;
    end else begin
      w_so_dec = c_nine;
      if (r_sec_tens != 4'd0) begin
        w_st_dec = r_sec_tens - 4'd1;
      end else begin
        w_st_dec = c_five;
        if (r_min_ones != 4'd0) begin
          w_mo_dec = r_min_ones - 4'd1;
        end else begin
          w_mo_dec = c_nine;
          w_mt_dec = r_min_tens - 4'd1;
        end
      end
    end
  end

  assign w_dec_zero = (w_mt_dec == 4'd0) && (w_mo_dec == 4'd0) &&
                      (w_st_dec == 4'd0) && (w_so_dec == 4'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_mt_nxt    = r_min_tens;
    w_mo_nxt    = r_min_ones;
    w_st_nxt    = r_sec_tens;
    w_so_nxt    = r_sec_ones;
    w_done_nxt  = 1'b0;
    case (r_state)
      SET: begin
        if (w_key_evt && (D <= c_nine)) begin
          w_mt_nxt = r_min_ones;
          w_mo_nxt = r_sec_tens;
          w_st_nxt = r_sec_ones;
          w_so_nxt = D;
        end
        if (!enablen && !zero) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        // A tick coinciding with a pause is applied before leaving RUN.
        if (w_tick_evt) begin
          w_mt_nxt = w_mt_dec;
          w_mo_nxt = w_mo_dec;
          w_st_nxt = w_st_dec;
          w_so_nxt = w_so_dec;
          if (w_dec_zero) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else if (enablen) begin
            w_state_nxt = SET;
          end
        end else if (enablen) begin
          w_state_nxt = SET;
        end
      end
      DONE: begin
        if (enablen) begin
          w_state_nxt = SET;
        end
      end
      default: begin
        w_state_nxt = SET;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_state    <= SET;
      r_min_tens <= 4'd0;
      r_min_ones <= 4'd0;
      r_sec_tens <= 4'd0;
      r_sec_ones <= 4'd0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_min_tens <= w_mt_nxt;
      r_min_ones <= w_mo_nxt;
      r_sec_tens <= w_st_nxt;
      r_sec_ones <= w_so_nxt;
      r_running  <= (w_state_nxt == RUN);
      r_done     <= w_done_nxt;
    end
  end

  assign min_tens = r_min_tens;
  assign min_ones = r_min_ones;
  assign sec_tens = r_sec_tens;
  assign sec_ones = r_sec_ones;
  assign running  = r_running;
  assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_timer_countdown.sv
// ============================================================================
// Module   : tb_timer_countdown
// Brief    : Self-checking bench for timer_countdown against an MM:SS model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_countdown;

  localparam int SYNC = 2;
  localparam int HOLD = SYNC + 3;

  logic       clk;
  logic       clearn;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;
  logic       enablen;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       zero, running, done;
  logic [15:0] dig;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: minutes and seconds as plain integers plus a mode.
  int m_mm;
  int m_ss;
  int m_mode;  // 0 stopped, 1 counting, 2 expired

  timer_countdown #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .clearn(clearn), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .enablen(enablen), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .zero(zero),
    .running(running), .done(done)
  );

  assign dig = {min_tens, min_ones, sec_tens, sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] exp_dig();
    exp_dig = {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10)};
  endfunction

  function automatic logic exp_zero();
    exp_zero = (m_mm == 0) && (m_ss == 0);
  endfunction

  function automatic void model_reset();
    m_mm = 0; m_ss = 0; m_mode = 0;
  endfunction

  function automatic void model_key(input int d);
    int v;
    if (m_mode == 0 && d <= 9) begin
      v = ((m_mm * 100 + m_ss) * 10 + d) % 10000;
      m_mm = v / 100;
      m_ss = v % 100;
    end
  endfunction

  function automatic void model_tick();
    if (m_mode == 1) begin
      if (m_ss > 0) m_ss = m_ss - 1;
      else begin m_ss = 59; m_mm = m_mm - 1; end
      if (m_mm == 0 && m_ss == 0) m_mode = 2;
    end
  endfunction

  function automatic void model_levels(input logic en);
    if (m_mode == 0 && !en && !(m_mm == 0 && m_ss == 0)) m_mode = 1;
    else if (m_mode == 1 && en) m_mode = 0;
    else if (m_mode == 2 && en) m_mode = 0;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    D = d; loadn = 1'b0;
    wait_clks(HOLD);
    loadn = 1'b1;
    wait_clks(HOLD);
    model_key(int'(d));
    model_levels(enablen);
  endtask

  task automatic tick();
    pgt_1Hz = 1'b1;
    wait_clks(HOLD);
    pgt_1Hz = 1'b0;
    wait_clks(HOLD);
    model_tick();
    model_levels(enablen);
  endtask

  task automatic set_en(input logic v);
    enablen = v;
    wait_clks(3);
    model_levels(enablen);
  endtask

  task automatic test_reset();
    n_cmp++;
    if (dig !== 16'h0000 || zero !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got dig=%h zero=%b run=%b done=%b want 0000/1/0/0",
               dig, zero, running, done);
    end
  endtask

  task automatic test_key_entry();
    press(4'd1); press(4'd3); press(4'd0);
    n_cmp++;
    if (dig !== 16'h0130 || zero !== 1'b0 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL key_entry: got dig=%h zero=%b run=%b want 0130/0/0", dig, zero, running);
    end
    repeat (3) tick();
    n_cmp++;
    if (dig !== exp_dig() || dig !== 16'h0130) begin
      n_fail++;
      $display("FAIL tick_in_set: got %h want 0130", dig);
    end
  endtask

  task automatic test_countdown();
    set_en(1'b0);
    n_cmp++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL run_start: got running=%b want 1", running);
    end
    // First tick checks the exact landing edge.
    pgt_1Hz = 1'b1;
    wait_clks(SYNC);
    n_cmp++;
    if (dig !== 16'h0130) begin
      n_fail++;
      $display("FAIL latency_early: got %h want 0130", dig);
    end
    wait_clks(1);
    n_cmp++;
    if (dig !== 16'h0129) begin
      n_fail++;
      $display("FAIL latency_land: got %h want 0129", dig);
    end
    wait_clks(HOLD - SYNC - 1);
    pgt_1Hz = 1'b0;
    wait_clks(HOLD);
    model_tick();
    model_levels(enablen);
    repeat (29) tick();
    n_cmp++;
    if (dig !== 16'h0100) begin
      n_fail++;
      $display("FAIL count_0100: got %h want 0100", dig);
    end
    tick();
    n_cmp++;
    if (dig !== 16'h0059 || dig !== exp_dig() || running !== 1'b1) begin
      n_fail++;
      $display("FAIL borrow_min: got %h run=%b want 0059 run=1", dig, running);
    end
  endtask

  task automatic test_done();
    int cnt;
    set_en(1'b1);
    press(4'd0); press(4'd0); press(4'd0); press(4'd2);
    set_en(1'b0);
    tick();
    n_cmp++;
    if (dig !== 16'h0001 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL done_pre: got %h run=%b want 0001 run=1", dig, running);
    end
    cnt = 0;
    pgt_1Hz = 1'b1;
    for (int i = 0; i < 2 * HOLD; i++) begin
      if (i == HOLD) pgt_1Hz = 1'b0;
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    model_tick();
    model_levels(enablen);
    n_cmp++;
    if (cnt != 1 || dig !== 16'h0000 || zero !== 1'b1 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got cycles=%0d dig=%h zero=%b run=%b want 1/0000/1/0",
               cnt, dig, zero, running);
    end
    cnt = 0;
    pgt_1Hz = 1'b1;
    for (int i = 0; i < 2 * HOLD; i++) begin
      if (i == HOLD) pgt_1Hz = 1'b0;
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
    model_tick();
    model_levels(enablen);
    n_cmp++;
    if (cnt != 0 || dig !== 16'h0000 || running !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold: got cycles=%0d dig=%h run=%b want 0/0000/0", cnt, dig, running);
    end
  endtask

  task automatic test_shift_invalid();
    set_en(1'b1);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    n_cmp++;
    if (dig !== 16'h2345) begin
      n_fail++;
      $display("FAIL shift_discard: got %h want 2345", dig);
    end
    press(4'hC);
    n_cmp++;
    if (dig !== 16'h2345) begin
      n_fail++;
      $display("FAIL invalid_digit: got %h want 2345", dig);
    end
    set_en(1'b0);
    press(4'd9);
    n_cmp++;
    if (dig !== 16'h2345 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL key_in_run: got %h run=%b want 2345 run=1", dig, running);
    end
  endtask

  task automatic test_pause();
    set_en(1'b1);
    press(4'd0); press(4'd0); press(4'd9); press(4'd0);
    set_en(1'b0);
    repeat (31) tick();
    n_cmp++;
    if (dig !== 16'h0059 || dig !== exp_dig()) begin
      n_fail++;
      $display("FAIL sec90: got %h want 0059", dig);
    end
    set_en(1'b1);
    tick();
    n_cmp++;
    if (running !== 1'b0 || dig !== 16'h0059) begin
      n_fail++;
      $display("FAIL pause: got %h run=%b want 0059 run=0", dig, running);
    end
    set_en(1'b0);
    tick();
    n_cmp++;
    if (running !== 1'b1 || dig !== 16'h0058) begin
      n_fail++;
      $display("FAIL resume: got %h run=%b want 0058 run=1", dig, running);
    end
  endtask

  task automatic test_reset_midrun();
    int cnt;
    set_en(1'b1);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    set_en(1'b0);
    n_cmp++;
    if (dig !== 16'h1234 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_abort: got %h run=%b want 1234 run=1", dig, running);
    end
    @(negedge clk);
    #2 clearn = 1'b0;
    #1;
    n_cmp++;
    if (dig !== 16'h0000 || zero !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_abort: got dig=%h zero=%b run=%b done=%b want 0000/1/0/0",
               dig, zero, running, done);
    end
    wait_clks(2);
    clearn = 1'b1;
    model_reset();
    cnt = 0;
    for (int i = 0; i < 2 * HOLD; i++) begin
      @(negedge clk);
      if (done === 1'b1 || dig !== 16'h0000 || running !== 1'b0) cnt++;
    end
    n_cmp++;
    if (cnt != 0) begin
      n_fail++;
      $display("FAIL release_quiet: got %0d disturbed cycles want 0", cnt);
    end
  endtask

  task automatic test_random();
    int act;
    for (int i = 0; i < 60; i++) begin
      act = int'($urandom_range(0, 9));
      if (act < 4) press(4'($urandom_range(0, 15)));
      else if (act < 8) tick();
      else set_en(~enablen);
      n_cmp++;
      if (dig !== exp_dig() || zero !== exp_zero() || running !== (m_mode == 1)) begin
        n_fail++;
        $display("FAIL random[%0d]: got dig=%h zero=%b run=%b want %h/%b/%b",
                 i, dig, zero, running, exp_dig(), exp_zero(), (m_mode == 1));
      end
    end
  endtask

  initial begin
    clearn = 1'b0; D = 4'd0; loadn = 1'b1; pgt_1Hz = 1'b0; enablen = 1'b1;
    wait_clks(3);
    clearn = 1'b1;
    wait_clks(3);
    model_reset();
    test_reset();
    test_key_entry();
    test_countdown();
    test_done();
    test_shift_invalid();
    test_pause();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timer_countdown.md
Name: timer_countdown

Overview:
- Receiving end of the keypad encoder interface. Consumes BCD digit D, key strobe loadn and tick pgt_1Hz.
- Shifts keyed digits into a 4-digit MM:SS register while the oven is stopped.
- Counts down once per pgt_1Hz tick while cooking. Flags expiry.
- Feeds the display decoders and the magnetron/door control logic.

Parameters:
SYNC_STAGES, 2, flip-flop stages synchronizing loadn and pgt_1Hz into the clk domain (min 2)

Ports:
clk  input  1  system clock
clearn  input  1  asynchronous active-low reset
D  input  4  BCD digit from encoder; valid while loadn low
loadn  input  1  low while a key is held; high = no key
pgt_1Hz  input  1  1 Hz tick; its rising edge is the count event
enablen  input  1  0 = cook/count enabled; 1 = stopped (digit entry allowed)
min_tens  output  4  BCD minutes tens
min_ones  output  4  BCD minutes ones
sec_tens  output  4  BCD seconds tens
sec_ones  output  4  BCD seconds ones
zero  output  1  1 when all four digits are 0
running  output  1  1 in state RUN
done  output  1  one-clk pulse when countdown reaches 0000

Behaviour:
- Reset (clearn=0, async) sets these values:
  - all digits 0, zero=1, running=0, done=0, state SET.
  - loadn synchronizer chain = 1; pgt_1Hz synchronizer chain = 0. No spurious event after reset release.
- Synchronization and edge detection:
  - loadn and pgt_1Hz each pass through SYNC_STAGES flops, then a 1-flop edge detector.
  - key_evt = synced loadn 1->0. tick_evt = synced pgt_1Hz 0->1. Each is one clk wide.
  - D is sampled in the cycle key_evt is asserted; the encoder holds D stable while loadn is low.
- Latency: a digit or count update lands on clk edge SYNC_STAGES+1 after the first edge that samples the input change.
- FSM states: SET, RUN, DONE.
  - SET: key_evt with D<=9 shifts the digits: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D. The old min_tens is discarded.
  - SET: key_evt with D>9 is ignored, no shift.
  - SET: tick_evt is ignored.
  - SET->RUN when enablen=0 and zero=0. With enablen=0 and zero=1, stay in SET.
  - RUN: on each tick_evt, decrement by one second with BCD borrow:
    - sec_ones 0 -> 9 and borrow into sec_tens.
    - sec_tens 0 -> 5 and borrow into min_ones.
    - min_ones 0 -> 9 and borrow into min_tens.
    - Entered sec_tens>5 (e.g. 0:90) is legal and counts down directly: 90, 89, ...
  - RUN: key_evt is ignored.
  - RUN->SET (pause) when enablen=1. Digits are retained.
  - RUN->DONE on the decrement that yields 0000. done=1 for exactly that one clk.
  - DONE: digits hold at 0000; all events are ignored. DONE->SET when enablen=1.
- Simultaneous events:
  - Same-cycle enablen rise and tick_evt in RUN: the tick is applied, then the FSM moves to SET.
  - key_evt and tick_evt in the same cycle: only the event legal in the current state acts.
- Outputs:
  - zero is combinational from the digit registers.
  - running and done are registered.
  - Digits never leave 0-9; no decrement occurs below 0000.
- Reset mid-RUN aborts immediately to the reset values. No done pulse.

Test Plan:
- Reset, then key 1,3,0 with enablen=1 -> digits 01:30, zero=0, running=0; ticks during SET leave 01:30.
- From 01:30, set enablen=0 and apply 31 ticks -> 00:59 after the 31st tick (01:00->00:59 borrow checked), running=1.
- Load 00:02, run, apply 2 ticks -> 00:01 then 00:00; done high for exactly 1 clk, state DONE; a 3rd tick leaves 00:00.
- Key 1,2,3,4,5 in SET -> 23:45. Key a D=4'hC -> no change. Key 9 with enablen=0 during RUN -> ignored.
- Load 00:90, run 31 ticks -> 00:59. Set enablen=1 mid-run -> running=0, digits frozen; enablen=0 -> resumes from the frozen value.
- Assert clearn low mid-RUN at 12:34 -> all digits 0, zero=1, running=0, done=0 asynchronously (before the next clk edge); no event fires on reset release.
